// File: rtl/pong_pkg.sv
// Shared definitions for the Pong game sequencer.
//   state_t    : game flow states (IDLE, SERVE, PLAY, POINT, OVER)
//   constants  : playfield geometry on the 64x64 grid
//   step_pos   : one-cell move of a 6-bit coordinate in either direction
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SERVE,
        ST_PLAY,
        ST_POINT,
        ST_OVER
    } state_t;

    localparam logic [5:0] CENTER     = 6'd31;
    localparam logic [5:0] LEFT_COL   = 6'd2;
    localparam logic [5:0] RIGHT_COL  = 6'd61;
    localparam logic [5:0] PADDLE_H   = 6'd6;
    localparam logic [5:0] GRID_MAX   = 6'd63;
    // Lowest top row that keeps the whole paddle on the grid.
    localparam logic [5:0] PADDLE_MAX = 6'(int'(GRID_MAX) + 1 - int'(PADDLE_H));
    // Paddle rows 29..34 straddle the centre row.
    localparam logic [5:0] PADDLE_INIT = 6'd29;

    // Adding GRID_MAX is a 6-bit decrement; range limits are guaranteed by
    // the caller, so the modulo wrap never actually happens.
    function automatic logic [5:0] step_pos(input logic [5:0] pos, input logic neg);
        return neg ? pos + GRID_MAX : pos + 6'd1;
    endfunction

endpackage

// File: rtl/pong_paddle.sv
// One paddle position register.
//   clk, rst : clock, synchronous active-high reset
//   en       : move enable (game tick while the paddles are live)
//   up, dn   : controls; exactly one pressed moves one row, saturating
//   y        : top row of the paddle, 0..PADDLE_MAX
module pong_paddle
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       up,
    input  logic       dn,
    output logic [5:0] y
);

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            y <= PADDLE_INIT;
        end else if (en) begin
            if (up && !dn && y != 6'd0)
                y <= y - 6'd1;
            else if (dn && !up && y != PADDLE_MAX)
                y <= y + 6'd1;
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: ball kinematics, paddles, scoring and game flow.
//   clk, rst          : clock, synchronous active-high reset
//   tick              : one-cycle frame-rate step enable
//   start             : level, acted on in IDLE and OVER only
//   p1_up/dn, p2_up/dn: paddle controls
//   paddle_collision  : detector flag, 01 = left paddle hit, 11 = right
//   wall_collision    : detector flag, ball on row 0 or 63
//   bx, by            : ball column / row
//   p1y, p2y          : paddle top rows
//   sc1, sc2          : scores
//   serving, game_over: status, registered with the state
//   winner            : 0 = P1, 1 = P2; meaningful while game_over is high
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_DELAY = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       p1_up,
    input  logic       p1_dn,
    input  logic       p2_up,
    input  logic       p2_dn,
    input  logic [1:0] paddle_collision,
    input  logic       wall_collision,
    output logic [5:0] bx,
    output logic [5:0] by,
    output logic [5:0] p1y,
    output logic [5:0] p2y,
    output logic [2:0] sc1,
    output logic [2:0] sc2,
    output logic       serving,
    output logic       game_over,
    output logic       winner
);

    localparam int CW = $clog2(SERVE_DELAY + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SERVE_DELAY - 1);
    localparam logic [2:0]    WIN      = 3'(WIN_SCORE);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          dx_neg, dy_neg;   // 1 = moving toward column/row 0
    logic          serve_p1;         // next serve heads toward P1

    logic paddles_live;
    logic miss_left, miss_right;
    logic ndx_neg, ndy_neg;

    assign paddles_live = tick && (state == ST_SERVE || state == ST_PLAY);

    pong_paddle u_p1 (.clk(clk), .rst(rst), .en(paddles_live), .up(p1_up), .dn(p1_dn), .y(p1y));
    pong_paddle u_p2 (.clk(clk), .rst(rst), .en(paddles_live), .up(p2_up), .dn(p2_dn), .y(p2y));

    // Bounce resolution: paddle and wall flips are independent, so a corner
    // hit flips both components before the move.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        ndx_neg    = dx_neg;
        ndy_neg    = wall_collision ? ~dy_neg : dy_neg;
        miss_left  = 1'b0;
        miss_right = 1'b0;
        if (bx == LEFT_COL) begin
            if (paddle_collision == 2'b01) ndx_neg = 1'b0;
            else                           miss_left = 1'b1;
        end else if (bx == RIGHT_COL) begin
            if (paddle_collision == 2'b11) ndx_neg = 1'b1;
            else                           miss_right = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bx        <= CENTER;
            by        <= CENTER;
            dx_neg    <= 1'b0;
            dy_neg    <= 1'b0;
            serve_p1  <= 1'b0;
            sc1       <= 3'd0;
            sc2       <= 3'd0;
            serving   <= 1'b0;
            game_over <= 1'b0;
            winner    <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        sc1     <= 3'd0;
                        sc2     <= 3'd0;
                        cnt     <= '0;
                        serving <= 1'b1;
                        state   <= ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    if (tick) begin
                        if (cnt == CNT_LAST) begin
                            serving <= 1'b0;
                            state   <= ST_PLAY;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_PLAY: begin
                    if (tick) begin
                        if (miss_left) begin
                            sc2      <= sc2 + 3'd1;
                            serve_p1 <= 1'b1;
                            state    <= ST_POINT;
                        end else if (miss_right) begin
                            sc1      <= sc1 + 3'd1;
                            serve_p1 <= 1'b0;
                            state    <= ST_POINT;
                        end else begin
                            dx_neg <= ndx_neg;
                            dy_neg <= ndy_neg;
                            bx     <= step_pos(bx, ndx_neg);
                            by     <= step_pos(by, ndy_neg);
                        end
                    end
                end
                ST_POINT: begin
                    // Single-cycle state; tick is deliberately not looked at.
                    if (sc1 == WIN || sc2 == WIN) begin
                        game_over <= 1'b1;
                        winner    <= (sc2 == WIN);
                        state     <= ST_OVER;
                    end else begin
                        bx      <= CENTER;
                        by      <= CENTER;
                        dx_neg  <= serve_p1;
                        dy_neg  <= 1'b0;
                        cnt     <= '0;
                        serving <= 1'b1;
                        state   <= ST_SERVE;
                    end
                end
                ST_OVER: begin
                    if (start) begin
                        sc1       <= 3'd0;
                        sc2       <= 3'd0;
                        bx        <= CENTER;
                        by        <= CENTER;
                        dx_neg    <= 1'b0;
                        dy_neg    <= 1'b0;
                        serve_p1  <= 1'b0;
                        cnt       <= '0;
                        game_over <= 1'b0;
                        winner    <= 1'b0;
                        serving   <= 1'b1;
                        state     <= ST_SERVE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl. The bench stands in for the collision
// detector: paddle/wall flags are driven directly to steer the ball along a
// hand-planned path, and every expected position below is worked out from
// that path.
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       rst, tick, start;
    logic       p1_up, p1_dn, p2_up, p2_dn;
    logic [1:0] paddle_collision;
    logic       wall_collision;
    logic [5:0] bx, by, p1y, p2y;
    logic [2:0] sc1, sc2;
    logic       serving, game_over, winner;

    int total = 0;
    int bad   = 0;

    pong_game_ctrl #(.WIN_SCORE(2), .SERVE_DELAY(32)) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start),
        .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn),
        .paddle_collision(paddle_collision), .wall_collision(wall_collision),
        .bx(bx), .by(by), .p1y(p1y), .p2y(p2y), .sc1(sc1), .sc2(sc2),
        .serving(serving), .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One clk edge with the given tick and detector flags, sampled 1 ns later.
    task automatic cyc(input logic t, input logic [1:0] pc, input logic wall);
        tick = t;
        paddle_collision = pc;
        wall_collision = wall;
        @(posedge clk);
        #1;
        tick = 1'b0;
        paddle_collision = 2'b00;
        wall_collision = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 2'b00, 1'b0);
    endtask

    task automatic check_ball(input string tag, input logic [5:0] ex, input logic [5:0] ey);
        check({tag, "_bx"}, bx, ex);
        check({tag, "_by"}, by, ey);
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; start = 1'b0;
        p1_up = 1'b0; p1_dn = 1'b0; p2_up = 1'b0; p2_dn = 1'b0;
        paddle_collision = 2'b00; wall_collision = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values
        check_ball("reset", 6'd31, 6'd31);
        check("reset_p1y", p1y, 29);
        check("reset_p2y", p2y, 29);
        check("reset_sc1", sc1, 0);
        check("reset_sc2", sc2, 0);
        check("reset_serving", serving, 0);
        check("reset_over", game_over, 0);
        check("reset_winner", winner, 0);

        // IDLE: paddles frozen
        p1_dn = 1'b1;
        ticks(3);
        p1_dn = 1'b0;
        check("idle_p1y_frozen", p1y, 29);

        // start -> SERVE
        start = 1'b1;
        cyc(1'b0, 2'b00, 1'b0);
        start = 1'b0;
        check("start_serving", serving, 1);

        // Serve ticks 1..29: drive P1 to the top and P2 to the bottom
        p1_up = 1'b1; p2_dn = 1'b1;
        ticks(29);
        check("p1_reach_top", p1y, 0);
        check("p2_reach_bottom", p2y, 58);
        // tick 30: P1 both pressed at 0, P2 down at 58
        p1_dn = 1'b1;
        ticks(1);
        check("p1_both_no_move", p1y, 0);
        check("p2_dn_sat_58", p2y, 58);
        // tick 31: P1 up alone at 0
        p1_dn = 1'b0; p2_dn = 1'b0;
        ticks(1);
        check("p1_up_sat_0", p1y, 0);
        check("serve_tick31_serving", serving, 1);
        check_ball("serve_held", 6'd31, 6'd31);
        p1_up = 1'b0;
        // tick 32: serve ends, ball not yet moved
        ticks(1);
        check("serve_tick32_serving", serving, 0);
        check_ball("serve_end", 6'd31, 6'd31);
        ticks(1);
        check_ball("first_move", 6'd32, 6'd32);

        // Steer to (61,41): 19 more moves, a wall flip, then 9 moves
        ticks(19);
        cyc(1'b1, 2'b00, 1'b1);          // -> (52,50) heading up
        ticks(9);
        check_ball("at_right", 6'd61, 6'd41);
        cyc(1'b1, 2'b11, 1'b0);          // right paddle hit
        check_ball("right_hit", 6'd60, 6'd40);
        check("right_hit_sc1", sc1, 0);

        // Steer to (2,0) heading up-left
        ticks(20);                        // (40,20)
        cyc(1'b1, 2'b00, 1'b1);          // (39,21) heading down
        ticks(8);                         // (31,29)
        cyc(1'b1, 2'b00, 1'b1);          // (30,28) heading up
        ticks(28);
        check_ball("at_corner", 6'd2, 6'd0);
        cyc(1'b1, 2'b01, 1'b1);          // paddle + wall on the same tick
        check_ball("corner_bounce", 6'd3, 6'd1);

        // Right miss
        ticks(58);
        check_ball("at_right2", 6'd61, 6'd59);
        cyc(1'b1, 2'b00, 1'b0);
        check("right_miss_sc1", sc1, 1);
        check("right_miss_bx_held", bx, 61);
        check("right_miss_not_serving", serving, 0);
        cyc(1'b0, 2'b00, 1'b0);          // POINT -> SERVE without a tick
        check("after_point_serving", serving, 1);
        check_ball("after_point_centre", 6'd31, 6'd31);
        ticks(32);
        check("serve2_done", serving, 0);
        ticks(1);
        check_ball("serve_to_p2", 6'd32, 6'd32);

        // First left miss: bounce off right, flip at wall, run to column 2
        ticks(29);                        // (61,61)
        cyc(1'b1, 2'b11, 1'b0);          // (60,62)
        cyc(1'b1, 2'b00, 1'b1);          // (59,61) heading up
        ticks(57);
        check_ball("at_left", 6'd2, 6'd4);
        cyc(1'b1, 2'b00, 1'b0);
        check("left_miss_sc2", sc2, 1);
        check("left_miss_not_over", game_over, 0);
        cyc(1'b1, 2'b00, 1'b0);          // tick during POINT is ignored
        check("point_tick_serving", serving, 1);
        check_ball("point_tick_centre", 6'd31, 6'd31);
        ticks(32);
        ticks(1);
        check_ball("serve_to_p1", 6'd30, 6'd32);

        // Second left miss -> game over
        ticks(28);
        check_ball("at_left2", 6'd2, 6'd60);
        cyc(1'b1, 2'b00, 1'b0);
        check("win_sc2", sc2, 2);
        check("win_over_not_yet", game_over, 0);
        cyc(1'b0, 2'b00, 1'b0);
        check("win_over", game_over, 1);
        check("win_winner", winner, 1);

        // OVER: frozen
        p1_dn = 1'b1;
        ticks(3);
        p1_dn = 1'b0;
        check("over_p1y_frozen", p1y, 0);
        check("over_bx_frozen", bx, 2);
        check("over_sc2_frozen", sc2, 2);
        check("over_still_over", game_over, 1);

        // start from OVER
        start = 1'b1;
        cyc(1'b0, 2'b00, 1'b0);
        start = 1'b0;
        check("restart_sc1", sc1, 0);
        check("restart_sc2", sc2, 0);
        check("restart_serving", serving, 1);
        check("restart_over", game_over, 0);
        check_ball("restart_centre", 6'd31, 6'd31);
        ticks(33);
        check_ball("restart_move", 6'd32, 6'd32);

        // Reset mid-PLAY
        rst = 1'b1;
        cyc(1'b1, 2'b00, 1'b0);
        rst = 1'b0;
        check_ball("rst_mid", 6'd31, 6'd31);
        check("rst_mid_p1y", p1y, 29);
        check("rst_mid_p2y", p2y, 29);
        check("rst_mid_sc1", sc1, 0);
        check("rst_mid_serving", serving, 0);
        check("rst_mid_over", game_over, 0);
        p1_up = 1'b1;
        ticks(1);
        p1_up = 1'b0;
        check("rst_mid_idle_frozen", p1y, 29);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game sequencer for the 64×64 Pong playfield. Owns ball position and velocity, both paddle positions, scores and the serve/play/point/game-over flow. Drives `bx`, `by`, `p1y` and `p2y` into the collision detector and consumes its `paddle_collision` and `wall_collision` flags. Scoring is decided here on registered state; the detector's own score outputs are not used.

## Interface
Parameters:
- `WIN_SCORE`, default 7: points needed to win; legal range 1..7.
- `SERVE_DELAY`, default 32: ticks the ball is held at centre before each serve; must be ≥1.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset; synchronous, active-high.
- `tick` in 1: one-cycle game-step enable at frame rate.
- `start` in 1: level; sampled only in IDLE and OVER.
- `p1_up`, `p1_dn`, `p2_up`, `p2_dn` in 1 each: paddle controls.
- `paddle_collision` in 2: from the detector. 00 = none, 01 = left paddle, 11 = right paddle.
- `wall_collision` in 1: from the detector; ball is on row 0 or row 63.
- `bx`, `by` out 6: ball column and row.
- `p1y`, `p2y` out 6: top row of each paddle.
- `sc1`, `sc2` out 3: scores.
- `serving` out 1: high in SERVE.
- `game_over` out 1: high in OVER.
- `winner` out 1: 0 = P1 won, 1 = P2 won; valid only while `game_over` is high.

## Operation
Reset values:
- `bx` = `by` = 31; `p1y` = `p2y` = 29; `sc1` = `sc2` = 0.
- `dx` = +1, `dy` = +1; serve side = P2.
- State IDLE; `serving` = `game_over` = `winner` = 0.

States:
- **IDLE**: ball at (31,31), paddles frozen. `start` → clear scores, go to SERVE.
- **SERVE**: ball held at (31,31); paddles move. A counter counts ticks. On the `SERVE_DELAY`-th tick, go to PLAY; the ball does not move on that tick.
- **PLAY**: on each tick, evaluate in this order using current registers and detector flags:
  - `bx` = 2 and `paddle_collision` = 01: set `dx` = +1.
  - `bx` = 2 and no left hit: increment `sc2`, set serve side = P1, go to POINT, ball does not move.
  - `bx` = 61 and `paddle_collision` = 11: set `dx` = −1.
  - `bx` = 61 and no right hit: increment `sc1`, set serve side = P2, go to POINT, ball does not move.
  - `wall_collision`: negate `dy`.
  - Otherwise, or after a bounce: `bx` += new `dx`, `by` += new `dy`. A simultaneous paddle and wall bounce flips both components on the same tick.
- **POINT**: lasts exactly one clk, independent of `tick`.
  - If `sc1` or `sc2` equals `WIN_SCORE`: go to OVER; `winner` = 1 if `sc2` reached it, else 0.
  - Otherwise: recentre the ball, set `dx` toward the serve side (+1 for P2, −1 for P1), set `dy` = +1, go to SERVE.
- **OVER**: everything frozen. `start` → clear scores, recentre the ball, serve toward P2, go to SERVE.

Paddles (SERVE and PLAY only, on tick):
- `up` alone: decrement the row, saturating at 0.
- `dn` alone: increment the row, saturating at 58.
- Both or neither pressed: no move.
- Paddle updates use the same tick as the ball. The detector sees the pre-update values.

Arithmetic:
- All positions are 6-bit unsigned.
- `bx` stays within 2..61 and `by` within 0..63 by construction, because a wall flip occurs before any move. No wrap is possible.
- Scores never exceed `WIN_SCORE`, so there is no wrap.

## Timing
- Every state update occurs on the `clk` edge where `tick` = 1. POINT and `start` transitions are exceptions and take effect on any edge.
- Latency from `start` to the first ball move: `SERVE_DELAY` + 1 ticks.
- A score update is visible one cycle after the miss tick. `game_over` asserts one cycle after that.
- `rst` overrides everything in any state, including mid-rally and mid-POINT. Outputs return to their reset values on the following edge.
- `tick` arriving during POINT is ignored.

## Structure
- **Package `pong_pkg`**: state enum (IDLE, SERVE, PLAY, POINT, OVER) and these constants:
  - `CENTER` = 31
  - `LEFT_COL` = 2
  - `RIGHT_COL` = 61
  - `PADDLE_H` = 6
  - `PADDLE_MAX` = 58
  - `GRID_MAX` = 63
- **Sub-module `pong_paddle`**: holds one paddle's position register, with ports `clk`, `rst`, `en`, `up`, `dn` and `y`. Instantiated twice.

## Test plan
- Reset, then `start`, then `SERVE_DELAY` = 32 ticks → `serving` falls. After the next tick: `bx` = 32, `by` = 32.
- Right-paddle hit: ball at (61,40), `paddle_collision` = 11 on a tick → `bx` = 60, `by` = 41, `sc1` unchanged.
- Right miss: ball at (61,40), `paddle_collision` = 00 → `sc1` = 1; one cycle in POINT; then SERVE with ball at (31,31). The first move after serve goes to (32,32).
- Corner case: ball at (2,0) with `dx` = −1, `dy` = −1, `paddle_collision` = 01 and `wall_collision` = 1 → ball at (3,1).
- Win: `WIN_SCORE` = 2, two consecutive left misses → `sc2` = 2, `game_over` = 1, `winner` = 1. Further ticks change nothing. `start` → scores 0, state SERVE.
- `p1_up` and `p1_dn` held together with `p1y` = 0 → no move. `p1_up` alone at 0 → stays 0. `p2_dn` alone at 58 → stays 58. `rst` asserted mid-PLAY → all outputs at reset values the next cycle.
